// File: rtl/izh_pkg.sv
// izh_pkg: shared types and defaults for the Izhikevich spike monitor
package izh_pkg;
    localparam int ISI_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    typedef logic signed [7:0] memv_t;
    typedef enum logic [1:0] {S_ARMED, S_FIRING, S_REFRACT} state_t;
endpackage

// File: rtl/izh_isi_fifo.sv
// izh_isi_fifo: show-ahead FIFO with level, full and empty flags
module izh_isi_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic          do_push, do_pop;
    assign empty   = level == '0;
    assign full    = level == (AW+1)'(DEPTH);
    // a pop frees the slot, so a full FIFO still accepts a simultaneous push
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr    <= '0;
            rd    <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr    <= '0;
            rd    <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                mem[wr] <= din;
                wr      <= wr + 1'b1;
            end
            if (do_pop) rd <= rd + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/izh_spike_monitor.sv
// izh_spike_monitor: spike detection with hysteresis/refractory, spike count and ISI FIFO
module izh_spike_monitor
    import izh_pkg::*;
#(
    parameter int ISI_W      = ISI_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int HYST       = 8,
    parameter int REFRACT    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    v_in,
    input  logic                          v_valid,
    input  logic [7:0]                    thresh,
    input  logic                          clear,
    output logic                          spike,
    output logic [15:0]                   spike_count,
    output logic [ISI_W-1:0]              isi_data,
    output logic                          isi_valid,
    input  logic                          isi_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int RW = REFRACT > 1 ? $clog2(REFRACT + 1) : 1;
    state_t            state, state_nx;
    logic [RW-1:0]     rcnt, rcnt_nx;
    memv_t             v_s, t_s;
    logic signed [8:0] lo;
    logic              above, below, fire, push, pop, full, empty, first_seen;
    logic [ISI_W-1:0]  isi_cnt, isi_inc;
    assign v_s   = v_in;
    assign t_s   = thresh;
    // re-arm level is computed in 9 bits so thresh - HYST never wraps
    assign lo    = {t_s[7], t_s} - 9'(HYST);
    assign above = v_s > t_s;
    assign below = $signed({v_s[7], v_s}) < lo;
    assign isi_inc = &isi_cnt ? isi_cnt : isi_cnt + 1'b1;
    assign push  = fire && first_seen;
    assign pop   = isi_valid && isi_ready && !clear;
    assign isi_valid = !empty;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ARMED;
            rcnt  <= '0;
        end else if (clear) begin
            state <= S_ARMED;
            rcnt  <= '0;
        end else begin
            state <= state_nx;
            rcnt  <= rcnt_nx;
        end
    end
    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        if (v_valid) begin
            case (state)
                S_ARMED:  if (above) state_nx = S_FIRING;
                S_FIRING: if (below) begin
                    state_nx = REFRACT == 0 ? S_ARMED : S_REFRACT;
                    rcnt_nx  = RW'(REFRACT);
                end
                S_REFRACT: begin
                    state_nx = rcnt <= RW'(1) ? S_ARMED : S_REFRACT;
                    rcnt_nx  = rcnt <= RW'(1) ? rcnt : rcnt - 1'b1;
                end
                default: state_nx = S_ARMED;
            endcase
        end
    end
    always_comb fire = v_valid && !clear && state == S_ARMED && above;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike       <= 1'b0;
            spike_count <= '0;
            isi_cnt     <= '0;
            first_seen  <= 1'b0;
            overflow    <= 1'b0;
        end else if (clear) begin
            spike       <= 1'b0;
            spike_count <= '0;
            isi_cnt     <= '0;
            first_seen  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            spike <= fire;
            if (fire) begin
                spike_count <= spike_count + 1'b1;
                isi_cnt     <= '0;
                first_seen  <= 1'b1;
            end else if (v_valid) begin
                isi_cnt <= isi_inc;
            end
            if (push && full && !pop) overflow <= 1'b1;
        end
    end
    izh_isi_fifo #(.W(ISI_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (isi_inc),
        .dout  (isi_data),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_izh_spike_monitor.sv
// tb_izh_spike_monitor: directed checks of spike detection, ISI measurement and FIFO
module tb_izh_spike_monitor;
    logic        clk = 1'b0;
    logic        rst, v_valid, clear, isi_ready;
    logic [7:0]  v_in, thresh;
    logic        spike, isi_valid, overflow;
    logic [15:0] spike_count, isi_data;
    logic [2:0]  fifo_level;
    int          n_cmp = 0;
    int          n_err = 0;

    izh_spike_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .v_in        (v_in),
        .v_valid     (v_valid),
        .thresh      (thresh),
        .clear       (clear),
        .spike       (spike),
        .spike_count (spike_count),
        .isi_data    (isi_data),
        .isi_valid   (isi_valid),
        .isi_ready   (isi_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic vld, input int v);
        v_valid = vld;
        v_in    = 8'(v);
        @(posedge clk);
        #1;
        v_valid = 1'b0;
    endtask

    task automatic samp(input int v);
        step(1'b1, v);
    endtask

    task automatic gap(input int n, input int v);
        repeat (n) samp(-60);
        samp(v);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1'b0, 0);
        clear = 1'b0;
    endtask

    task automatic pop_one();
        isi_ready = 1'b1;
        step(1'b0, 0);
        isi_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; v_valid = 1'b0; clear = 1'b0; isi_ready = 1'b0;
        v_in = '0; thresh = 8'd16;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_spike", spike, 0);
        chk("rst_count", spike_count, 0);
        chk("rst_isi_valid", isi_valid, 0);
        chk("rst_isi_data", isi_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;

        repeat (10) begin
            samp(-60);
            chk("quiet_spike", spike, 0);
        end
        chk("quiet_count", spike_count, 0);
        chk("quiet_isi_valid", isi_valid, 0);

        do_clear();
        gap(9, 20);
        chk("s10_spike", spike, 1);
        chk("s10_count", spike_count, 1);
        chk("s10_no_push", isi_valid, 0);
        samp(-60);
        chk("spike_one_cycle", spike, 0);
        gap(13, 20);
        chk("s25_spike", spike, 1);
        chk("s25_count", spike_count, 2);
        chk("s25_isi_valid", isi_valid, 1);
        chk("s25_isi", isi_data, 15);
        chk("s25_level", fifo_level, 1);
        pop_one();
        chk("pop_isi_valid", isi_valid, 0);
        chk("pop_level", fifo_level, 0);

        samp(10);
        chk("hyst_10", spike, 0);
        samp(20);
        chk("hyst_20", spike, 0);
        samp(5);
        samp(20);
        chk("refr_a", spike, 0);
        samp(20);
        chk("refr_b", spike, 0);
        samp(20);
        chk("rearm_spike", spike, 1);
        chk("rearm_count", spike_count, 3);
        chk("rearm_isi", isi_data, 6);
        pop_one();

        do_clear();
        samp(20);
        gap(3, 20);
        gap(4, 20);
        gap(5, 20);
        gap(6, 20);
        chk("full_level", fifo_level, 4);
        chk("full_no_ovf", overflow, 0);
        gap(7, 20);
        chk("ovf_count", spike_count, 6);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", isi_data, 4 + i);
            pop_one();
        end
        chk("ovf_drained", isi_valid, 0);
        chk("ovf_sticky", overflow, 1);

        do_clear();
        chk("clr_ovf", overflow, 0);
        samp(20);
        gap(3, 20);
        gap(4, 20);
        gap(5, 20);
        gap(6, 20);
        repeat (8) samp(-60);
        isi_ready = 1'b1;
        samp(20);
        isi_ready = 1'b0;
        chk("pp_level", fifo_level, 4);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", isi_data, 5);
        pop_one();
        chk("pp_2", isi_data, 6);
        pop_one();
        chk("pp_3", isi_data, 7);
        pop_one();
        chk("pp_new", isi_data, 9);
        pop_one();
        chk("pp_empty", isi_valid, 0);

        do_clear();
        samp(20);
        repeat (5) begin
            repeat (3) step(1'b0, 20);
            samp(-60);
        end
        repeat (3) step(1'b0, 20);
        samp(20);
        chk("gap_count", spike_count, 2);
        chk("gap_isi", isi_data, 6);
        repeat (3) samp(-60);
        clear = 1'b1;
        samp(20);
        clear = 1'b0;
        chk("clr_spike", spike, 0);
        chk("clr_count", spike_count, 0);
        chk("clr_level", fifo_level, 0);
        chk("clr_isi_valid", isi_valid, 0);
        samp(20);
        chk("post_clr_spike", spike, 1);
        chk("post_clr_no_push", isi_valid, 0);

        repeat (3) samp(-60);
        samp(20);
        chk("pre_rst_spike", spike, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_spike", spike, 0);
        chk("async_rst_count", spike_count, 0);
        chk("async_rst_level", fifo_level, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
